// File: rtl/sar_divider_core.sv
// Restoring SAR divider: one quotient bit per clock, valid/ready on both sides.
// Define SAR_DIV_SIGNED_EN for two's-complement operands (signed_mode, SIGN state).
module sar_divider_core #(
  parameter int BITS      = 40,
  parameter int FRAC_BITS = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] dividendo,
  input  logic [BITS-1:0] divisor,
`ifdef SAR_DIV_SIGNED_EN
  input  logic            signed_mode,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] result,
  output logic [BITS-1:0] remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int N  = BITS + FRAC_BITS;
  localparam int CW = $clog2(N + 1);

`ifdef SAR_DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, CALC, DONE, SIGN} state_t;
  localparam state_t LAST = SIGN;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam state_t LAST = DONE;
`endif

  state_t state, state_nx;

  logic [CW-1:0]   cnt;
  logic [N-1:0]    num;
  logic [BITS-1:0] r;
  logic [BITS-1:0] d;
  logic [BITS-1:0] a;
  logic            dz;

  logic [BITS-1:0] mag_a;
  logic [BITS-1:0] mag_b;
  logic [BITS:0]   sh;
  logic            fits;
  logic [BITS-1:0] r_nx;
  logic [N-1:0]    q_nx;
  logic            ovf_nx;

`ifdef SAR_DIV_SIGNED_EN
  localparam logic [BITS-1:0] HALF = BITS'(1) << (BITS - 1);

  logic sa, sb;
  logic sq, sr, sm;
  logic ovf_s;

  assign sa    = signed_mode & dividendo[BITS-1];
  assign sb    = signed_mode & divisor[BITS-1];
  assign mag_a = sa ? -dividendo : dividendo;
  assign mag_b = sb ? -divisor : divisor;
  // magnitude quotient must fit the signed range of the result
  assign ovf_s = sm & (sq ? (num[BITS-1:0] > HALF)
                          : num[BITS-1]);
`else
  assign mag_a = dividendo;
  assign mag_b = divisor;
`endif

  // numerator shifts out of num's MSB while quotient bits fill its LSB
  assign sh   = {r, num[N-1]};
  assign fits = sh[BITS] | (sh[BITS-1:0] >= d);
  assign r_nx = fits ? sh[BITS-1:0] - d : sh[BITS-1:0];
  assign q_nx = {num[N-2:0], fits};

  if (FRAC_BITS > 0) begin : g_frac
    assign ovf_nx = |q_nx[N-1:BITS];
  end else begin : g_nofrac
    assign ovf_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (dz)                  state_nx = DONE;
        else if (cnt == CW'(1)) state_nx = LAST;
      end
`ifdef SAR_DIV_SIGNED_EN
      SIGN: state_nx = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      num         <= '0;
      r           <= '0;
      d           <= '0;
      a           <= '0;
      dz          <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef SAR_DIV_SIGNED_EN
      sq          <= 1'b0;
      sr          <= 1'b0;
      sm          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cnt         <= CW'(N);
          num         <= N'(mag_a) << FRAC_BITS;
          r           <= '0;
          d           <= mag_b;
          a           <= dividendo;
          dz          <= (divisor == '0);
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
`ifdef SAR_DIV_SIGNED_EN
          sq          <= sa ^ sb;
          sr          <= sa;
          sm          <= signed_mode;
`endif
        end
        CALC: begin
          if (dz) begin
            result      <= '1;
            remainder   <= a;
            div_by_zero <= 1'b1;
          end else begin
            num <= q_nx;
            r   <= r_nx;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              overflow  <= ovf_nx;
`ifndef SAR_DIV_SIGNED_EN
              result    <= q_nx[BITS-1:0];
              remainder <= r_nx;
`endif
            end
          end
        end
`ifdef SAR_DIV_SIGNED_EN
        SIGN: begin
          result    <= sq ? -num[BITS-1:0] : num[BITS-1:0];
          remainder <= sr ? -r : r;
          overflow  <= overflow | ovf_s;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_divider_core.sv
// Bench for sar_divider_core: a 40.0 instance and a 16.8 fixed-point instance
// checked against plain-arithmetic reference models.
module tb_sar_divider_core;

`ifdef SAR_DIV_SIGNED_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif
  localparam int LATA = 40 + XL;
  localparam int LATB = 24 + XL;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        av, ar, aov, aor, adz, aovf;
  logic [39:0] ax, ay, ares, arem;
  logic        bv, br, bov, bor, bdz, bovf;
  logic [15:0] bx, by, bres, brem;

  sar_divider_core #(.BITS(40), .FRAC_BITS(0)) u_a (
    .clk(clk), .reset(reset),
    .in_valid(av), .in_ready(ar),
    .dividendo(ax), .divisor(ay),
`ifdef SAR_DIV_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .out_valid(aov), .out_ready(aor),
    .result(ares), .remainder(arem),
    .div_by_zero(adz), .overflow(aovf)
  );

  sar_divider_core #(.BITS(16), .FRAC_BITS(8)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(bv), .in_ready(br),
    .dividendo(bx), .divisor(by),
`ifdef SAR_DIV_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .out_valid(bov), .out_ready(bor),
    .result(bres), .remainder(brem),
    .div_by_zero(bdz), .overflow(bovf)
  );

  // {result, remainder, div_by_zero, overflow}
  function automatic logic [81:0] model_a(input logic [39:0] x, input logic [39:0] y);
    if (y == '0) return {40'hFF_FFFF_FFFF, x, 2'b10};
    return {x / y, x % y, 2'b00};
  endfunction

  function automatic logic [33:0] model_b(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] n, q, m;
    if (y == '0) return {16'hFFFF, x, 2'b10};
    n = {8'h00, x, 8'h00};
    q = n / {16'h0000, y};
    m = n % {16'h0000, y};
    return {q[15:0], m[15:0], 1'b0, |q[31:16]};
  endfunction

  task automatic go_a(input logic [39:0] x, input logic [39:0] y, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!ar && w < 200) begin
      @(negedge clk);
      w++;
    end
    ax = x;
    ay = y;
    av = 1'b1;
    @(posedge clk);
    #1 av = 1'b0;
    lat = -1;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (aov) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic go_b(input logic [15:0] x, input logic [15:0] y, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!br && w < 200) begin
      @(negedge clk);
      w++;
    end
    bx = x;
    by = y;
    bv = 1'b1;
    @(posedge clk);
    #1 bv = 1'b0;
    lat = -1;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (bov) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic pop_a();
    aor = 1'b1;
    @(negedge clk);
    aor = 1'b0;
  endtask

  task automatic pop_b();
    bor = 1'b1;
    @(negedge clk);
    bor = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ar, aov, ares, arem, adz, aovf} !== {2'b10, 82'd0}) begin
      errors++;
      $display("FAIL reset_a got rdy=%b ov=%b res=%h rem=%h dz=%b of=%b want 1 0 0 0 0 0",
               ar, aov, ares, arem, adz, aovf);
    end
    checks++;
    if ({br, bov, bres, brem, bdz, bovf} !== {2'b10, 34'd0}) begin
      errors++;
      $display("FAIL reset_b got rdy=%b ov=%b res=%h rem=%h dz=%b of=%b want 1 0 0 0 0 0",
               br, bov, bres, brem, bdz, bovf);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ar, aov, br, bov} !== 4'b1010) begin
      errors++;
      $display("FAIL post_reset got a_rdy=%b a_ov=%b b_rdy=%b b_ov=%b want 1 0 1 0",
               ar, aov, br, bov);
    end
  endtask

  task automatic test_vector40();
    int lat;
    go_a(40'd425332234, 40'd62254, lat);
    checks++;
    if ({ares, arem, adz, aovf} !== {40'd6832, 40'd12906, 2'b00}) begin
      errors++;
      $display("FAIL vec40 got res=%0d rem=%0d dz=%b of=%b want 6832 12906 0 0",
               ares, arem, adz, aovf);
    end
    checks++;
    if (lat !== LATA) begin
      errors++;
      $display("FAIL vec40_latency got %0d want %0d", lat, LATA);
    end
    pop_a();
  endtask

  task automatic test_frac16();
    int lat;
    logic [33:0] e;
    go_b(16'd7, 16'd2, lat);
    checks++;
    if ({bres, brem, bdz, bovf} !== {16'h0380, 16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL frac_7_2 got res=%h rem=%h dz=%b of=%b want 0380 0000 0 0",
               bres, brem, bdz, bovf);
    end
    checks++;
    if (lat !== LATB) begin
      errors++;
      $display("FAIL frac_latency got %0d want %0d", lat, LATB);
    end
    pop_b();
    go_b(16'h8000, 16'd1, lat);
    checks++;
    if ({bres, brem, bdz, bovf} !== {16'h0000, 16'h0000, 2'b01}) begin
      errors++;
      $display("FAIL frac_ovf got res=%h rem=%h dz=%b of=%b want 0000 0000 0 1",
               bres, brem, bdz, bovf);
    end
    pop_b();
    go_b(16'h1234, 16'h0007, lat);
    e = model_b(16'h1234, 16'h0007);
    checks++;
    if ({bres, brem, bdz, bovf} !== e) begin
      errors++;
      $display("FAIL frac_1234_7 got %h want %h", {bres, brem, bdz, bovf}, e);
    end
    pop_b();
  endtask

  task automatic test_div_zero();
    int lat;
    go_a(40'd100, 40'd0, lat);
    checks++;
    if ({ares, arem, adz, aovf} !== {40'hFF_FFFF_FFFF, 40'd100, 2'b10}) begin
      errors++;
      $display("FAIL dz_a got res=%h rem=%0d dz=%b of=%b want ffffffffff 100 1 0",
               ares, arem, adz, aovf);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL dz_a_latency got %0d want 1", lat);
    end
    pop_a();
    go_b(16'd100, 16'd0, lat);
    checks++;
    if ({bres, brem, bdz, bovf, lat == 1} !== {16'hFFFF, 16'd100, 3'b101}) begin
      errors++;
      $display("FAIL dz_b got res=%h rem=%0d dz=%b of=%b lat=%0d want ffff 100 1 0 1",
               bres, brem, bdz, bovf, lat);
    end
    pop_b();
  endtask

  task automatic test_random();
    int lat;
    logic [39:0] x, y;
    logic [15:0] u, v;
    logic [81:0] ea;
    logic [33:0] eb;
    for (int i = 0; i < 12; i++) begin
      x = 40'({$urandom, $urandom});
      y = 40'({$urandom, $urandom}) >> $urandom_range(39, 0);
      if (i == 3) y = '0;
      ea = model_a(x, y);
      go_a(x, y, lat);
      checks++;
      if ({ares, arem, adz, aovf} !== ea || lat !== ((y == '0) ? 1 : LATA)) begin
        errors++;
        $display("FAIL rand_a %h/%h got %h lat=%0d want %h", x, y,
                 {ares, arem, adz, aovf}, lat, ea);
      end
      pop_a();
      u = 16'($urandom);
      v = 16'($urandom) >> $urandom_range(15, 0);
      if (i == 5) v = '0;
      eb = model_b(u, v);
      go_b(u, v, lat);
      checks++;
      if ({bres, brem, bdz, bovf} !== eb || lat !== ((v == '0) ? 1 : LATB)) begin
        errors++;
        $display("FAIL rand_b %h/%h got %h lat=%0d want %h", u, v,
                 {bres, brem, bdz, bovf}, lat, eb);
      end
      pop_b();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [81:0] e;
    e = model_a(40'd1000000, 40'd7);
    go_a(40'd1000000, 40'd7, lat);
    checks++;
    if ({ares, arem, adz, aovf} !== e || lat !== LATA) begin
      errors++;
      $display("FAIL bp_first got %h lat=%0d want %h", {ares, arem, adz, aovf}, lat, e);
    end
    ax = 40'd5;
    ay = 40'd1;
    av = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({aov, ar, ares, arem, adz, aovf} !== {2'b10, e}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got ov=%b rdy=%b res=%h rem=%h want ov=1 rdy=0 %h",
                 c, aov, ar, ares, arem, e);
      end
    end
    av = 1'b0;
    pop_a();
    checks++;
    if ({ar, aov} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release got rdy=%b ov=%b want 1 0", ar, aov);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({ar, aov} !== 2'b10) begin
      errors++;
      $display("FAIL bp_ignored got rdy=%b ov=%b want 1 0", ar, aov);
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exq[$];
    int acc[$];
    logic [33:0] got;
    logic [15:0] x, y;
    int n;
    n = 0;
    bor = 1'b1;
    for (int c = 0; c < 4 * (LATB + 2); c++) begin
      @(negedge clk);
      if (bov) begin
        checks++;
        got = {bres, brem, bdz, bovf};
        if (exq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_valid cycle %0d got %h want no out_valid", c, got);
        end else begin
          if (got !== exq[0]) begin
            errors++;
            $display("FAIL b2b_result cycle %0d got %h want %h", c, got, exq[0]);
          end
          void'(exq.pop_front());
        end
      end
      if (br) begin
        if (n < 3) begin
          x = 16'($urandom);
          y = 16'($urandom_range(255, 1));
          bx = x;
          by = y;
          bv = 1'b1;
          exq.push_back(model_b(x, y));
          acc.push_back(c);
          n++;
        end else begin
          bv = 1'b0;
        end
      end
    end
    bv = 1'b0;
    bor = 1'b0;
    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending got %0d outstanding want 0", exq.size());
    end
    checks++;
    if (acc.size() != 3 || acc[1] - acc[0] != LATB + 2 || acc[2] - acc[1] != LATB + 2) begin
      errors++;
      $display("FAIL b2b_interval got accepts=%0d gaps=%0d,%0d want 3 gaps of %0d",
               acc.size(), acc[1] - acc[0], acc[2] - acc[1], LATB + 2);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [81:0] e;
    @(negedge clk);
    ax = 40'd987654321;
    ay = 40'd123;
    av = 1'b1;
    @(posedge clk);
    #1 av = 1'b0;
    repeat (20) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ar, aov, ares, arem, adz, aovf} !== {2'b10, 82'd0}) begin
      errors++;
      $display("FAIL mid_reset_a got rdy=%b ov=%b res=%h rem=%h dz=%b of=%b want 1 0 0 0 0 0",
               ar, aov, ares, arem, adz, aovf);
    end
    checks++;
    if ({br, bov, bres, brem, bdz, bovf} !== {2'b10, 34'd0}) begin
      errors++;
      $display("FAIL mid_reset_b got rdy=%b ov=%b res=%h rem=%h want 1 0 0 0", br, bov, bres, brem);
    end
    @(negedge clk);
    reset = 1'b1;
    e = model_a(40'd555555555, 40'd777);
    go_a(40'd555555555, 40'd777, lat);
    checks++;
    if ({ares, arem, adz, aovf} !== e || lat !== LATA) begin
      errors++;
      $display("FAIL after_reset got %h lat=%0d want %h lat=%0d",
               {ares, arem, adz, aovf}, lat, e, LATA);
    end
    pop_a();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    av = 1'b0; ax = '0; ay = '0; aor = 1'b0;
    bv = 1'b0; bx = '0; by = '0; bor = 1'b0;
    test_reset();
    test_vector40();
    test_frac16();
    test_div_zero();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
